// File: rtl/sic_issue_dispatch_pkg.sv
// Shared types for the issue-dispatch stage.
// Contents: the default sic_packet_t layout, the {pkt, mask} FIFO entry type,
// the FIFO depth, and pkt_bits(), which returns the packet width for a given
// register/ID/ECR configuration. The valid bit is always the packet MSB.
package sic_issue_dispatch_pkg;

  localparam int unsigned SIC_DISPATCH_DEPTH = 2;
  localparam int unsigned OPC_W              = 8;

  localparam int unsigned DEF_NUM_SICS     = 4;
  localparam int unsigned DEF_NUM_PHY_REGS = 64;
  localparam int unsigned DEF_ID_WIDTH     = 8;
  localparam int unsigned DEF_NUM_ECRS     = 4;

  localparam int unsigned DEF_PREG_W = $clog2(DEF_NUM_PHY_REGS);
  localparam int unsigned DEF_ECR_W  = $clog2(DEF_NUM_ECRS);

  // Packet width: valid + id + dst/src1/src2 register tags + ecr + opcode.
  function automatic int unsigned pkt_bits(int unsigned num_phy_regs,
                                           int unsigned id_width,
                                           int unsigned num_ecrs);
    return 1 + id_width + 3 * $clog2(num_phy_regs) + $clog2(num_ecrs) + OPC_W;
  endfunction

  typedef struct packed {
    logic                    valid;
    logic [DEF_ID_WIDTH-1:0] id;
    logic [DEF_PREG_W-1:0]   dst;
    logic [DEF_PREG_W-1:0]   src1;
    logic [DEF_PREG_W-1:0]   src2;
    logic [DEF_ECR_W-1:0]    ecr;
    logic [OPC_W-1:0]        opcode;
  } sic_packet_t;

  typedef struct packed {
    sic_packet_t             pkt;
    logic [DEF_NUM_SICS-1:0] mask;
  } sic_dispatch_entry_t;

endpackage

// File: rtl/sic_issue_dispatch_if.sv
// Issue-queue / sub-SIC bus for the dispatch stage.
// Signals: in_pkt, in_target_mask, flush, sic_req_instr (towards the dispatcher);
// in_ready, sic_pkt[NUM_SICS], drop_pulse (from the dispatcher).
// master = issue queue plus sub-SIC side, slave = dispatcher.
interface sic_issue_dispatch_if #(
  parameter int unsigned NUM_SICS = 4,
  parameter int unsigned P        = sic_issue_dispatch_pkg::pkt_bits(64, 8, 4)
);
  logic [P-1:0]                in_pkt;
  logic [NUM_SICS-1:0]         in_target_mask;
  logic                        in_ready;
  logic                        flush;
  logic [NUM_SICS-1:0]         sic_req_instr;
  logic [NUM_SICS-1:0][P-1:0]  sic_pkt;
  logic                        drop_pulse;

  modport master (
    output in_pkt, in_target_mask, flush, sic_req_instr,
    input  in_ready, sic_pkt, drop_pulse
  );

  modport slave (
    input  in_pkt, in_target_mask, flush, sic_req_instr,
    output in_ready, sic_pkt, drop_pulse
  );
endinterface

// File: rtl/sic_issue_dispatch_rr_arbiter.sv
// Rotating-priority arbiter: the first requester at or after i_ptr wins.
// With i_ptr held at zero it is a plain lowest-index priority encoder.
// Ports: i_req[N] requests, i_ptr highest-priority index,
//        o_gnt_c one-hot grant, o_gnt_idx_c grant index (both combinational).
module sic_issue_dispatch_rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_gnt_c,
  output logic [$clog2(N)-1:0] o_gnt_idx_c
);
  localparam int unsigned IDX_W = $clog2(N);

  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  // Scan N positions starting at i_ptr, wrapping modulo N.
  always_comb begin
    o_gnt_c     = '0;
    o_gnt_idx_c = '0;
    w_idx       = '0;
    w_found     = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = IDX_W'((32'(i_ptr) + k) % N);
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_gnt_c[w_idx] = 1'b1;
        o_gnt_idx_c    = w_idx;
      end
    end
  end
endmodule

// File: rtl/sic_issue_dispatch.sv
// Dispatch stage: buffers up to two issue packets and hands each one, in
// order, to one eligible ready sub-SIC as a registered one-cycle valid pulse.
// Ports: clk, rst_n (async, active-low), bus (sic_issue_dispatch_if.slave):
//   in_pkt/in_target_mask/in_ready enqueue side, flush, sic_req_instr,
//   sic_pkt[NUM_SICS] dispatch outputs, drop_pulse for zero-mask packets.
// Build option: define SIC_DISPATCH_RR_EN for round-robin arbitration;
// otherwise the lowest-indexed ready target wins and no rotation state exists.
module sic_issue_dispatch
  import sic_issue_dispatch_pkg::*;
#(
  parameter int unsigned NUM_SICS     = 4,
  parameter int unsigned NUM_PHY_REGS = 64,
  parameter int unsigned NUM_ECRS     = 4,
  parameter int unsigned ID_WIDTH     = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  sic_issue_dispatch_if.slave bus
);
  localparam int unsigned P     = pkt_bits(NUM_PHY_REGS, ID_WIDTH, NUM_ECRS);
  localparam int unsigned E     = P + NUM_SICS;
  localparam int unsigned IDX_W = $clog2(NUM_SICS);

  logic [E-1:0]               r_fifo [SIC_DISPATCH_DEPTH];
  logic [1:0]                 r_count;
  logic                       r_wr_ptr;
  logic                       r_rd_ptr;
  logic                       r_in_ready;
  logic                       r_drop_pulse;
  logic [NUM_SICS-1:0][P-1:0] r_sic_pkt;

  logic                       w_accept;
  logic                       w_push;
  logic                       w_drop;
  logic                       w_pop;
  logic [E-1:0]               w_head;
  logic [P-1:0]               w_head_pkt;
  logic [NUM_SICS-1:0]        w_head_mask;
  logic [NUM_SICS-1:0]        w_req;
  logic [NUM_SICS-1:0]        w_gnt;
  logic [IDX_W-1:0]           w_gnt_idx;
  logic [IDX_W-1:0]           w_arb_ptr;
  logic [1:0]                 w_count_next;

  // Enqueue qualification; a zero-mask packet is consumed but never stored.
  assign w_accept = bus.in_pkt[P-1] && r_in_ready && !bus.flush;
  assign w_push   = w_accept && (bus.in_target_mask != '0);
  assign w_drop   = w_accept && (bus.in_target_mask == '0);

  assign w_head      = r_fifo[r_rd_ptr];
  assign w_head_pkt  = w_head[E-1:NUM_SICS];
  assign w_head_mask = w_head[NUM_SICS-1:0];

  // Only the head competes; flush suppresses the grant in its own cycle.
  assign w_req = (r_count != 2'd0 && !bus.flush) ? (w_head_mask & bus.sic_req_instr) : '0;
  assign w_pop = |w_gnt;

  sic_issue_dispatch_rr_arbiter #(.N(NUM_SICS)) u_arb (
    .i_req       (w_req),
    .i_ptr       (w_arb_ptr),
    .o_gnt_c     (w_gnt),
    .o_gnt_idx_c (w_gnt_idx)
  );

`ifdef SIC_DISPATCH_RR_EN
  logic [IDX_W-1:0] r_rr_ptr;

  // Priority moves to the slot after the last winner; flush leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_pop) begin
      r_rr_ptr <= (w_gnt_idx == IDX_W'(NUM_SICS - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
    end
  end

  assign w_arb_ptr = r_rr_ptr;
`else
  assign w_arb_ptr = '0;
`endif

  // Occupancy after this cycle's push/pop or flush.
  always_comb begin
    w_count_next = r_count;
    if (bus.flush) begin
      w_count_next = 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_next = 2'(r_count + 2'd1);
        2'b01:   w_count_next = 2'(r_count - 2'd1);
        default: w_count_next = r_count;
      endcase
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SIC_DISPATCH_DEPTH); i++) r_fifo[i] <= '0;
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      r_count <= w_count_next;
      if (bus.flush) begin
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
      end else begin
        if (w_push) begin
          r_fifo[r_wr_ptr] <= {bus.in_pkt, bus.in_target_mask};
          r_wr_ptr         <= ~r_wr_ptr;
        end
        if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

  // Registered outputs; sic_pkt is rebuilt every cycle so valid is a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready   <= 1'b1;
      r_drop_pulse <= 1'b0;
      r_sic_pkt    <= '0;
    end else begin
      r_in_ready   <= (w_count_next < 2'(SIC_DISPATCH_DEPTH));
      r_drop_pulse <= w_drop;
      r_sic_pkt    <= '0;
      if (w_pop) r_sic_pkt[w_gnt_idx] <= w_head_pkt;
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.drop_pulse = r_drop_pulse;
  assign bus.sic_pkt    = r_sic_pkt;

endmodule
